// File: rtl/ps2_cmd_seq.sv
// ps2_cmd_seq: host-side command sequencer for a PS/2 keyboard.
// Issues the LED update (ED, {5'b0,leds}) and keyboard reset (FF, then
// wait for the AA/FC self-test reply) sequences through a ps2 core.
// Each byte must be answered with FA. FE, a transmit timeout or a missing
// reply causes a resend, up to MAX_RETRY resends per byte. Received bytes
// that are not part of a command handshake are forwarded as scan codes.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   led_req, leds       LED update request pulse and {caps,num,scroll}
//   kbd_rst_req         keyboard reset request pulse
//   busy, done, err     sequence active / success pulse / sticky error
//   bat_ok              last keyboard reset completed with AA
//   oreq, obyte, oack   transmit request, byte and completion from the core
//   timeout             transmit timeout level from the core
//   istrobe, ibyte      received byte strobe and data from the core
//   kstrobe, kbyte      forwarded scan code strobe and data
module ps2_cmd_seq #(
  parameter int ACK_WAIT  = 500000,
  parameter int BAT_WAIT  = 25000000,
  parameter int MAX_RETRY = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       led_req,
  input  logic [2:0] leds,
  input  logic       kbd_rst_req,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       bat_ok,
  output logic       oreq,
  output logic [7:0] obyte,
  input  logic       oack,
  input  logic       timeout,
  input  logic       istrobe,
  input  logic [7:0] ibyte,
  output logic       kstrobe,
  output logic [7:0] kbyte
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SEND     = 3'd1;
  localparam logic [2:0] WAIT_TX  = 3'd2;
  localparam logic [2:0] WAIT_ACK = 3'd3;
  localparam logic [2:0] WAIT_BAT = 3'd4;
  localparam logic [2:0] FINISH   = 3'd5;

  localparam logic [24:0] ACK_LOAD  = 25'(ACK_WAIT);
  localparam logic [24:0] BAT_LOAD  = 25'(BAT_WAIT);
  localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);

  logic [2:0]  state;
  logic        pend_led;
  logic        pend_rst;
  logic [2:0]  pend_leds;
  logic [2:0]  cur_leds;
  logic        is_rst;     // current sequence is a keyboard reset
  logic        step;       // LED sequence: 0 = ED byte, 1 = data byte
  logic [7:0]  retry;
  logic [24:0] cnt;
  logic [7:0]  tx_byte;
  logic        consumed;
  logic        fail;

  assign busy  = (state != IDLE);
  assign oreq  = (state == SEND);
  // The byte source registers only change in IDLE and WAIT_ACK, so obyte
  // stays stable from SEND through WAIT_TX.
  assign obyte = (state == SEND || state == WAIT_TX) ? tx_byte : '0;

  always_comb begin
    tx_byte = 8'hED;
    if (is_rst)
      tx_byte = 8'hFF;
    else if (step)
      tx_byte = {5'b0, cur_leds};
  end

  always_comb begin
    consumed = 1'b0;
    if (istrobe) begin
      if (state == WAIT_ACK && (ibyte == 8'hFA || ibyte == 8'hFE))
        consumed = 1'b1;
      if (state == WAIT_BAT && (ibyte == 8'hAA || ibyte == 8'hFC))
        consumed = 1'b1;
    end
  end

  // A received byte takes precedence over reply-counter expiry.
  always_comb begin
    fail = 1'b0;
    if (state == WAIT_TX && !oack && timeout)
      fail = 1'b1;
    if (state == WAIT_ACK) begin
      if (istrobe)
        fail = (ibyte == 8'hFE);
      else
        fail = (cnt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pend_led  <= 1'b0;
      pend_rst  <= 1'b0;
      pend_leds <= '0;
      cur_leds  <= '0;
      is_rst    <= 1'b0;
      step      <= 1'b0;
      retry     <= '0;
      cnt       <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      bat_ok    <= 1'b0;
      kstrobe   <= 1'b0;
      kbyte     <= '0;
    end else begin
      done    <= 1'b0;
      kstrobe <= istrobe && !consumed;
      if (istrobe && !consumed)
        kbyte <= ibyte;

      if (led_req) begin
        pend_led  <= 1'b1;
        pend_leds <= leds;
      end
      if (kbd_rst_req)
        pend_rst <= 1'b1;

      case (state)
        IDLE: begin
          // Same-cycle requests are accepted directly; the pending flag
          // assignments below override the ones set just above.
          if (pend_rst || kbd_rst_req) begin
            pend_rst <= 1'b0;
            is_rst   <= 1'b1;
            step     <= 1'b0;
            retry    <= '0;
            err      <= 1'b0;
            state    <= SEND;
          end else if (pend_led || led_req) begin
            pend_led <= 1'b0;
            is_rst   <= 1'b0;
            step     <= 1'b0;
            cur_leds <= led_req ? leds : pend_leds;
            retry    <= '0;
            err      <= 1'b0;
            state    <= SEND;
          end
        end
        SEND: state <= WAIT_TX;
        WAIT_TX: begin
          if (oack) begin
            cnt   <= ACK_LOAD;
            state <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (istrobe && ibyte == 8'hFA) begin
            retry <= '0;
            if (is_rst) begin
              cnt   <= BAT_LOAD;
              state <= WAIT_BAT;
            end else if (!step) begin
              step  <= 1'b1;
              state <= SEND;
            end else begin
              state <= FINISH;
            end
          end else if (!istrobe && cnt != '0) begin
            cnt <= cnt - 25'd1;
          end
        end
        WAIT_BAT: begin
          if (istrobe && ibyte == 8'hAA) begin
            bat_ok <= 1'b1;
            state  <= FINISH;
          end else if (istrobe && ibyte == 8'hFC) begin
            bat_ok <= 1'b0;
            err    <= 1'b1;
            state  <= FINISH;
          end else if (cnt == '0) begin
            bat_ok <= 1'b0;
            err    <= 1'b1;
            state  <= FINISH;
          end else begin
            cnt <= cnt - 25'd1;
          end
        end
        FINISH: begin
          done  <= !err;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (fail) begin
        if (retry == RETRY_MAX) begin
          err <= 1'b1;
          if (is_rst)
            bat_ok <= 1'b0;
          state <= FINISH;
        end else begin
          retry <= retry + 8'd1;
          state <= SEND;
        end
      end
    end
  end

endmodule

// File: doc/ps2_cmd_seq.md
PS2_CMD_SEQ -- requirements
Module: ps2_cmd_seq

Interface
REQ-001 Parameter ACK_WAIT, default 500000: clk cycles allowed for an FA/FE reply after a transmitted byte.
REQ-002 Parameter BAT_WAIT, default 25000000: clk cycles allowed for the AA/FC reply after a reset command.
REQ-003 Parameter MAX_RETRY, default 3: resends allowed per byte before the error exit.
REQ-004 clk  in  1  system clock; the only clock.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 led_req  in  1  one-cycle pulse; requests an LED update.
REQ-007 leds  in  3  {caps, num, scroll}, sampled on the same cycle as led_req.
REQ-008 kbd_rst_req  in  1  one-cycle pulse; requests a keyboard reset (FF).
REQ-009 busy  out  1  high while a command sequence is active.
REQ-010 done  out  1  one-cycle pulse on successful completion of a sequence.
REQ-011 err  out  1  sticky error flag; cleared when the next sequence starts.
REQ-012 bat_ok  out  1  high after a reset that completed with AA; cleared on FC or on a reset error exit.
REQ-013 oreq  out  1  one-cycle transmit request to the ps2 core.
REQ-014 obyte  out  8  transmit byte for the ps2 core.
REQ-015 oack  in  1  transmit-complete pulse from the ps2 core.
REQ-016 timeout  in  1  transmit-timeout level from the ps2 core.
REQ-017 istrobe  in  1  one-cycle receive strobe from the ps2 core.
REQ-018 ibyte  in  8  received byte, valid while istrobe is high.
REQ-019 kstrobe  out  1  forwarded scan-code strobe.
REQ-020 kbyte  out  8  forwarded scan-code byte.

Function
REQ-021 FSM states are IDLE, SEND, WAIT_TX, WAIT_ACK, WAIT_BAT and FINISH.
REQ-022 In IDLE with a pending request, the FSM goes to SEND on the next cycle; a pending reset has priority over a pending LED request.
REQ-023 led_req or kbd_rst_req arriving while busy sets a one-entry pending flag, and the latest leds value overwrites any earlier one.
REQ-024 The LED sequence is: byte ED, then FA, then byte {5'b0, leds}, then FA, then FINISH.
REQ-025 The reset sequence is: byte FF, then FA, then WAIT_BAT; AA sets bat_ok and goes to FINISH; FC clears bat_ok, sets err and goes to FINISH.
REQ-026 SEND asserts oreq for exactly one cycle, drives obyte, and enters WAIT_TX.
REQ-027 obyte is held stable from SEND until WAIT_TX is exited.
REQ-028 In WAIT_TX, oack moves the FSM to WAIT_ACK and loads the reply counter with ACK_WAIT; timeout=1 counts as a failed attempt.
REQ-029 In WAIT_ACK, FA advances the sequence and resets the retry count to 0.
REQ-030 In WAIT_ACK, FE, reply-counter expiry, or a failed attempt resends the same byte through SEND and increments the retry count.
REQ-031 A failure with retry count equal to MAX_RETRY sets err and goes to FINISH without another resend.
REQ-032 In WAIT_BAT the reply counter is loaded with BAT_WAIT; expiry sets err, clears bat_ok and goes to FINISH.
REQ-033 FINISH lasts one cycle, pulses done only if err is clear, and returns to IDLE.
REQ-034 busy is high in every state except IDLE.
REQ-035 An istrobe byte consumed by the FSM (FA/FE in WAIT_ACK, AA/FC in WAIT_BAT) is not forwarded.
REQ-036 Every other istrobe byte, in any state, is forwarded: kstrobe=1 and kbyte=ibyte on the following cycle.
REQ-037 An istrobe in the same cycle as reply-counter expiry is handled as the received byte; expiry is ignored on that cycle.
REQ-038 The reply counter is 25 bits, counts down, and is checked for zero.

Reset
REQ-039 While rst=1 the FSM is forced to IDLE on the next clk edge regardless of current state, including mid-transmission.
REQ-040 While rst=1, pending flags, retry count and counter are cleared.
REQ-041 While rst=1, oreq, busy, done, err, bat_ok and kstrobe are driven to 0, and obyte and kbyte to 8'h00.

Verification
REQ-042 led_req with leds=3'b101 -> oreq with ED; oack; FA -> oreq with 05; oack; FA -> one done pulse, busy low, err=0.
REQ-043 kbd_rst_req -> FF; oack; FA; AA -> bat_ok=1, done pulse.
REQ-044 Same reset flow ending in FC instead of AA -> err=1, bat_ok=0, no done.
REQ-045 LED update answered with FE four times (MAX_RETRY=3) -> ED transmitted 4 times, then err=1, no done.
REQ-046 No reply after oack (ACK_WAIT=16 in the bench) -> resend at cycle 17.
REQ-047 Scan code 1C received during WAIT_ACK -> kstrobe with kbyte=1C, sequence unaffected.
REQ-048 led_req while busy -> second LED sequence starts right after FINISH, using the latest leds.
REQ-049 rst asserted in WAIT_TX -> all outputs at reset values on the next cycle.
